// File: rtl/axi_wr_arb.sv
// axi_wr_arb: round-robin sharing of one AXI4 write master port among NREQ requesters,
// one full AW/W/B burst per grant, with sticky per-requester beat-count error flags.
module axi_wr_arb #(
  parameter int NREQ = 2,
  parameter int DW   = 64,
  parameter int AW   = 32,
  parameter int IW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*AW-1:0]   s_awaddr,
  input  logic [NREQ*8-1:0]    s_awlen,
  input  logic [NREQ-1:0]      s_awvalid,
  output logic [NREQ-1:0]      s_awready,
  input  logic [NREQ*DW-1:0]   s_wdata,
  input  logic [NREQ*DW/8-1:0] s_wstrb,
  input  logic [NREQ-1:0]      s_wlast,
  input  logic [NREQ-1:0]      s_wvalid,
  output logic [NREQ-1:0]      s_wready,
  output logic [1:0]           s_bresp,
  output logic [NREQ-1:0]      s_bvalid,
  input  logic [NREQ-1:0]      s_bready,
  output logic [IW-1:0]        m_awid,
  output logic [AW-1:0]        m_awaddr,
  output logic [7:0]           m_awlen,
  output logic [2:0]           m_awsize,
  output logic [1:0]           m_awburst,
  output logic [3:0]           m_awcache,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [DW-1:0]        m_wdata,
  output logic [DW/8-1:0]      m_wstrb,
  output logic                 m_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic                 busy,
  output logic [NREQ-1:0]      err_len,
  input  logic                 err_clr
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     g_q, g_d, last_q, last_d, sel;
  logic [7:0]        len_q, len_d, len_sel;
  logic [8:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]   err_q, err_d, oh;
  logic [AW-1:0]     awaddr_g;
  logic [7:0]        awlen_g;
  logic [DW-1:0]     wdata_g;
  logic [DW/8-1:0]   wstrb_g;
  logic              wvalid_g, wlast_g, bready_g, whs;
  int                best, d;
  // d is the round-robin distance of requester i from the slot after last_q
  always_comb begin
    sel = '0;
    len_sel = '0;
    best = NREQ;
    d = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2 * NREQ - int'(last_q) - 1) % NREQ;
      if (s_awvalid[i] && d < best) begin
        best = d;
        sel = IW'(i);
        len_sel = s_awlen[i*8 +: 8];
      end
    end
  end
  always_comb begin
    awaddr_g = '0;
    awlen_g = '0;
    wdata_g = '0;
    wstrb_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_q == IW'(i)) begin
        awaddr_g = s_awaddr[i*AW +: AW];
        awlen_g = s_awlen[i*8 +: 8];
        wdata_g = s_wdata[i*DW +: DW];
        wstrb_g = s_wstrb[i*DW/8 +: DW/8];
      end
    end
  end
  assign oh        = NREQ'(1) << g_q;
  assign wvalid_g  = |(s_wvalid & oh);
  assign wlast_g   = |(s_wlast & oh);
  assign bready_g  = |(s_bready & oh);
  assign busy      = state_q != IDLE;
  assign m_awvalid = state_q == ADDR;
  assign m_awid    = m_awvalid ? g_q : '0;
  assign m_awaddr  = m_awvalid ? awaddr_g : '0;
  assign m_awlen   = m_awvalid ? awlen_g : '0;
  assign m_awsize  = 3'($clog2(DW / 8));
  assign m_awburst = 2'b01;
  assign m_awcache = 4'b0010;
  assign s_awready = (m_awvalid && m_awready) ? oh : '0;
  assign m_wvalid  = state_q == DATA && wvalid_g;
  assign m_wlast   = state_q == DATA && wlast_g;
  assign m_wdata   = state_q == DATA ? wdata_g : '0;
  assign m_wstrb   = state_q == DATA ? wstrb_g : '0;
  assign s_wready  = (state_q == DATA && m_wready) ? oh : '0;
  assign whs       = m_wvalid && m_wready;
  assign s_bvalid  = (state_q == RESP && m_bvalid) ? oh : '0;
  assign s_bresp   = state_q == RESP ? m_bresp : '0;
  assign m_bready  = state_q == RESP && bready_g;
  assign err_len   = err_q;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    last_d = last_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_clr ? '0 : err_q;
    case (state_q)
      IDLE: if (|s_awvalid) begin
        g_d = sel;
        len_d = len_sel;
        state_d = ADDR;
      end
      ADDR: if (m_awready) begin
        cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (whs) begin
        cnt_d = (cnt_q == 9'd511) ? cnt_q : cnt_q + 9'd1;
        err_d = (wlast_g ? cnt_q != {1'b0, len_q} : cnt_q == {1'b0, len_q}) ? err_d | oh : err_d;
        state_d = wlast_g ? RESP : DATA;
      end
      RESP: if (m_bvalid && bready_g) begin
        last_d = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      last_q <= IW'(NREQ - 1);
      len_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      last_q <= last_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_wr_arb.sv
// tb_axi_wr_arb: directed scenario tasks for axi_wr_arb driven by requester and slave models.
module tb_axi_wr_arb;
  localparam int NREQ = 2, DW = 64, AW = 32, IW = 3;
  logic clk = 0, rst = 1;
  logic [NREQ*AW-1:0] s_awaddr;
  logic [NREQ*8-1:0] s_awlen;
  logic [NREQ-1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready, err_len;
  logic [NREQ*DW-1:0] s_wdata;
  logic [NREQ*DW/8-1:0] s_wstrb;
  logic [1:0] s_bresp, m_awburst, m_bresp;
  logic [IW-1:0] m_awid;
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize;
  logic [3:0] m_awcache;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready, busy, err_clr;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  int n_chk = 0, n_pass = 0;

  axi_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .busy(busy), .err_len(err_len), .err_clr(err_clr));

  always #5 clk = ~clk;

  // requester model state: bursts pending, beat on which wlast is driven, configured fields
  int pend[NREQ], lastb[NREQ], beat[NREQ];
  bit wact[NREQ], inb[NREQ], awhs[NREQ], whs[NREQ], bhs[NREQ];
  logic [AW-1:0] addr_c[NREQ];
  logic [7:0] len_c[NREQ];
  // slave model state
  int aw_delay = 0, b_delay = 0, awcnt = 0, bcnt = 0;
  bit wtog = 0, bpend = 0, mwl_hs = 0, mb_hs = 0;
  logic [1:0] bresp_c = 2'b00;
  logic [IW-1:0] awlog[$];
  int wbeats = 0, overlap = 0;

  function automatic logic [DW-1:0] pat(input int r, input int b);
    return {24'hA5A5A5, 8'(r), 32'(b)};
  endfunction

  always begin
    @(negedge clk);
    if (rst) begin
      for (int r = 0; r < NREQ; r++) begin
        pend[r] = 0; wact[r] = 0; inb[r] = 0; awhs[r] = 0; whs[r] = 0; bhs[r] = 0; beat[r] = 0;
      end
      s_awvalid = '0;
      bpend = 0; bcnt = 0; awcnt = 0; mwl_hs = 0; mb_hs = 0;
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (awhs[r]) begin s_awvalid[r] = 1'b0; wact[r] = 1; beat[r] = 0; inb[r] = 1; end
        if (whs[r]) begin if (s_wlast[r]) wact[r] = 0; beat[r]++; end
        if (bhs[r]) begin inb[r] = 0; pend[r]--; end
        if (!inb[r] && pend[r] > 0) s_awvalid[r] = 1'b1;
      end
      if (mwl_hs) bpend = 1;
      if (mb_hs) begin bpend = 0; bcnt = 0; end
    end
    for (int r = 0; r < NREQ; r++) begin
      s_awaddr[r*AW +: AW] = addr_c[r];
      s_awlen[r*8 +: 8] = len_c[r];
      s_wvalid[r] = wact[r];
      s_wlast[r] = wact[r] && beat[r] == lastb[r];
      s_wdata[r*DW +: DW] = pat(r, beat[r]);
    end
    m_awready = awcnt >= aw_delay;
    m_wready = wtog ? !m_wready : 1'b1;
    m_bvalid = bpend && bcnt >= b_delay;
    m_bresp = bresp_c;
    #1;
    for (int r = 0; r < NREQ; r++) begin
      awhs[r] = s_awvalid[r] && s_awready[r];
      whs[r] = s_wvalid[r] && s_wready[r];
      bhs[r] = s_bvalid[r] && s_bready[r];
    end
    if (m_awvalid && m_awready) begin awlog.push_back(m_awid); awcnt = 0; end
    else if (m_awvalid) awcnt++;
    if (m_wvalid && m_wready) wbeats++;
    if ($countones(s_wready) > 1) overlap++;
    mwl_hs = m_wvalid && m_wready && m_wlast;
    mb_hs = m_bvalid && m_bready;
    if (bpend && !m_bvalid) bcnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1;
    aw_delay = 0; b_delay = 0; wtog = 0; bresp_c = 2'b00; err_clr = 0;
    for (int r = 0; r < NREQ; r++) begin len_c[r] = 8'd3; lastb[r] = 3; end
    cyc(); cyc();
    rst = 0;
    awlog.delete(); wbeats = 0; overlap = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      cyc();
      if (pend[0] == 0 && pend[1] == 0 && !busy) ok = 1;
    end
  endtask

  task automatic test_reset();
    cyc();
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b000) $display("FAIL reset_mvalid: got %b exp 000", {m_awvalid, m_wvalid, m_bready}); else n_pass++;
    n_chk++; if ({s_awready, s_wready, s_bvalid} !== 6'b0) $display("FAIL reset_sready: got %b exp 0", {s_awready, s_wready, s_bvalid}); else n_pass++;
    n_chk++; if (err_len !== 2'b00) $display("FAIL reset_err: got %b exp 00", err_len); else n_pass++;
    n_chk++; if ({m_awid, m_awaddr, m_awlen, s_bresp} !== '0) $display("FAIL reset_fields: got %h exp 0", {m_awid, m_awaddr, m_awlen, s_bresp}); else n_pass++;
    n_chk++; if ({m_awsize, m_awburst, m_awcache} !== {3'd3, 2'b01, 4'b0010}) $display("FAIL const_fields: got %h exp %h", {m_awsize, m_awburst, m_awcache}, {3'd3, 2'b01, 4'b0010}); else n_pass++;
  endtask

  task automatic test_single();
    bit seen_aw = 0, prev_b = 0, ok = 0;
    int nb = 0;
    do_reset();
    pend[0] = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (prev_b) begin
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b exp 0", busy); else n_pass++;
        ok = 1;
      end
      if (m_awvalid && !seen_aw) begin
        seen_aw = 1;
        n_chk++; if (m_awid !== 3'd0) $display("FAIL single_awid: got %0d exp 0", m_awid); else n_pass++;
        n_chk++; if (m_awaddr !== 32'h1000) $display("FAIL single_awaddr: got %h exp 1000", m_awaddr); else n_pass++;
        n_chk++; if (m_awlen !== 8'd3) $display("FAIL single_awlen: got %0d exp 3", m_awlen); else n_pass++;
        n_chk++; if (s_awready !== 2'b01) $display("FAIL single_awready: got %b exp 01", s_awready); else n_pass++;
      end
      if (m_wvalid && m_wready) begin
        nb++;
        n_chk++; if (m_wlast !== (nb == 4)) $display("FAIL single_wlast beat %0d: got %b exp %b", nb, m_wlast, nb == 4); else n_pass++;
      end
      if (m_bvalid) begin
        n_chk++; if (s_bvalid !== 2'b01 || busy !== 1'b1) $display("FAIL single_bvalid: got %b/%b exp 01/1", s_bvalid, busy); else n_pass++;
      end
      prev_b = s_bvalid[0] && s_bready[0];
    end
    n_chk++; if (!ok) $display("FAIL single_timeout: got no B handshake exp one"); else n_pass++;
    n_chk++; if (nb != 4) $display("FAIL single_beats: got %0d exp 4", nb); else n_pass++;
    n_chk++; if (err_len !== 2'b00) $display("FAIL single_err: got %b exp 00", err_len); else n_pass++;
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    len_c[0] = 0; len_c[1] = 0; lastb[0] = 0; lastb[1] = 0;
    pend[0] = 2; pend[1] = 2;
    wait_done(ok);
    n_chk++; if (!ok) $display("FAIL alt_timeout: got busy exp idle"); else n_pass++;
    n_chk++; if (awlog.size() != 4) $display("FAIL alt_count: got %0d exp 4", awlog.size()); else n_pass++;
    for (int i = 0; i < 4 && i < awlog.size(); i++) begin
      n_chk++; if (awlog[i] !== IW'(i % 2)) $display("FAIL alt_grant %0d: got %0d exp %0d", i, awlog[i], i % 2); else n_pass++;
    end
    n_chk++; if (overlap != 0 || wbeats != 4) $display("FAIL alt_w: got overlap %0d beats %0d exp 0 4", overlap, wbeats); else n_pass++;
  endtask

  task automatic test_no_starve();
    bit ok1, ok2;
    logic [IW-1:0] exp_g[9] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    do_reset();
    len_c[0] = 0; len_c[1] = 0; lastb[0] = 0; lastb[1] = 0;
    pend[1] = 1;
    wait_done(ok1);
    pend[0] = 4; pend[1] = 4;
    wait_done(ok2);
    n_chk++; if (!(ok1 && ok2)) $display("FAIL rr_timeout: got busy exp idle"); else n_pass++;
    n_chk++; if (awlog.size() != 9) $display("FAIL rr_count: got %0d exp 9", awlog.size()); else n_pass++;
    for (int i = 0; i < 9 && i < awlog.size(); i++) begin
      n_chk++; if (awlog[i] !== exp_g[i]) $display("FAIL rr_grant %0d: got %0d exp %0d", i, awlog[i], exp_g[i]); else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    int nb = 0, stall = 0, rwait = 0;
    bit ok = 0;
    do_reset();
    aw_delay = 5; wtog = 1; b_delay = 10; bresp_c = 2'b10;
    pend[0] = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      cyc();
      if (m_awvalid) begin
        n_chk++; if (s_awready !== {1'b0, m_awready}) $display("FAIL bp_awready: got %b exp %b", s_awready, {1'b0, m_awready}); else n_pass++;
        if (!m_awready) stall++;
      end
      if (busy && nb == 4 && !m_wvalid && !m_awvalid && !s_bvalid[0]) rwait++;
      if (m_wvalid) begin
        n_chk++; if (m_wdata !== pat(0, nb)) $display("FAIL bp_wdata: got %h exp %h", m_wdata, pat(0, nb)); else n_pass++;
        if (m_wready) nb++;
      end
      if (s_bvalid[0]) begin
        n_chk++; if (s_bresp !== 2'b10) $display("FAIL bp_bresp: got %b exp 10", s_bresp); else n_pass++;
        ok = s_bready[0];
      end
    end
    n_chk++; if (!ok) $display("FAIL bp_timeout: got no B handshake exp one"); else n_pass++;
    n_chk++; if (stall != 5) $display("FAIL bp_aw_stall: got %0d exp 5", stall); else n_pass++;
    n_chk++; if (nb != 4) $display("FAIL bp_beats: got %0d exp 4", nb); else n_pass++;
    n_chk++; if (rwait != 10) $display("FAIL bp_b_wait: got %0d exp 10", rwait); else n_pass++;
  endtask

  task automatic test_len_err();
    bit after = 0, ok;
    int nb = 0;
    do_reset();
    lastb[0] = 1;
    pend[0] = 1;
    for (int i = 0; i < 40 && pend[0] != 0; i++) begin
      cyc();
      if (after) begin
        n_chk++; if (err_len !== 2'b01) $display("FAIL short_err: got %b exp 01", err_len); else n_pass++;
        n_chk++; if ({busy, s_wready, m_bready} !== 4'b1001) $display("FAIL short_resp: got %b exp 1001", {busy, s_wready, m_bready}); else n_pass++;
        after = 0;
      end
      if (m_wvalid && m_wready && m_wlast) after = 1;
    end
    wait_done(ok);
    n_chk++; if (!ok || err_len !== 2'b01) $display("FAIL short_sticky: got %b ok %b exp 01", err_len, ok); else n_pass++;
    err_clr = 1;
    cyc();
    err_clr = 0;
    n_chk++; if (err_len !== 2'b00) $display("FAIL err_clr: got %b exp 00", err_len); else n_pass++;
    lastb[0] = 5;
    pend[0] = 1;
    for (int i = 0; i < 40 && pend[0] != 0; i++) begin
      cyc();
      if (after) begin
        n_chk++; if (err_len !== 2'b01 || s_wready !== 2'b01) $display("FAIL long_err: got %b/%b exp 01/01", err_len, s_wready); else n_pass++;
        after = 0;
      end
      if (m_wvalid && m_wready) begin nb++; after = nb == 4; end
    end
    wait_done(ok);
    n_chk++; if (!ok || nb != 6) $display("FAIL long_beats: got %0d exp 6", nb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, hit = 0;
    int nb = 0;
    do_reset();
    pend[0] = 1;
    wait_done(ok);
    pend[0] = 1;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc();
      if (m_wvalid && m_wready) begin
        if (nb == 1) hit = 1;
        nb++;
      end
    end
    n_chk++; if (!(ok && hit)) $display("FAIL mid_reach: got %b exp 1", ok && hit); else n_pass++;
    rst = 1;
    #1;
    n_chk++; if ({busy, m_awvalid, m_wvalid, m_bready} !== 4'b0000) $display("FAIL mid_mout: got %b exp 0000", {busy, m_awvalid, m_wvalid, m_bready}); else n_pass++;
    n_chk++; if ({s_awready, s_wready, s_bvalid} !== 6'b0) $display("FAIL mid_sout: got %b exp 0", {s_awready, s_wready, s_bvalid}); else n_pass++;
    cyc(); cyc();
    rst = 0;
    awlog.delete();
    pend[0] = 1; pend[1] = 1;
    wait_done(ok);
    n_chk++; if (!ok || awlog.size() != 2) $display("FAIL mid_count: got %0d exp 2", awlog.size()); else n_pass++;
    n_chk++; if (awlog.size() == 0 || awlog[0] !== 3'd0) $display("FAIL mid_first_grant: got %0d exp 0", awlog.size() ? awlog[0] : 3'd7); else n_pass++;
  endtask

  initial begin
    s_bready = '1;
    s_wstrb = '1;
    err_clr = 0;
    addr_c[0] = 32'h1000;
    addr_c[1] = 32'h2000;
    for (int r = 0; r < NREQ; r++) begin len_c[r] = 8'd3; lastb[r] = 3; end
    test_reset();
    test_single();
    test_alternate();
    test_no_starve();
    test_back_pressure();
    test_len_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_wr_arb.md
Name: axi_wr_arb

Overview:
- Shares one AXI4 write master port (AW/W/B) between NREQ write requesters, e.g. the 3DNR current-frame writer and the reference-frame writer, in front of the DDR interconnect.
- Round-robin grant. Each grant is held for one complete burst: AW, then all W beats, then B.
- Checks W beat count against AWLEN and reports mismatches on sticky error flags.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DW, 64, data width (bits)
- AW, 32, address width
- IW, 3, master ID width (≥ clog2(NREQ))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_awaddr  in  NREQ*AW  requester i burst address, slice [i*AW +: AW]
- s_awlen  in  NREQ*8  requester i burst length-1
- s_awvalid  in  NREQ  requester i address valid
- s_awready  out  NREQ  address accepted
- s_wdata  in  NREQ*DW  write data
- s_wstrb  in  NREQ*DW/8  write strobes
- s_wlast  in  NREQ  last beat
- s_wvalid  in  NREQ  data valid
- s_wready  out  NREQ  data ready
- s_bresp  out  2  response (broadcast; qualified by s_bvalid)
- s_bvalid  out  NREQ  response valid
- s_bready  in  NREQ  response ready
- m_awid  out  IW  = granted index
- m_awaddr, m_awlen  out  AW, 8  granted fields
- m_awsize  out  3  constant clog2(DW/8)
- m_awburst  out  2  constant 2'b01
- m_awcache  out  4  constant 4'b0010
- m_awvalid  out  1  / m_awready  in  1
- m_wdata, m_wstrb, m_wlast, m_wvalid  out  DW, DW/8, 1, 1
- m_wready  in  1
- m_bresp  in  2 / m_bvalid  in  1 / m_bready  out  1
- busy  out  1  state != IDLE
- err_len  out  NREQ  sticky per-requester beat-count error
- err_clr  in  1  clears err_len

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all valid/ready outputs 0; m_awid/m_awaddr/m_awlen/m_wdata/m_wstrb/m_wlast/s_bresp 0.
  - last_grant=NREQ-1, so requester 0 has priority first; beat_cnt=0; err_len=0.
- IDLE:
  - If any s_awvalid is set, select the first set bit searching upward from last_grant+1 (wrapping).
  - Register the grant index g and s_awlen[g] into len_q; go to ADDR.
  - One cycle of arbitration latency. Non-selected requesters see no ready.
- ADDR:
  - m_awvalid=1; m_awid=g; m_awaddr/m_awlen muxed from g.
  - s_awready[g]=m_awready (combinational); all other s_awready=0.
  - On m_awvalid&&m_awready: beat_cnt=0; go to DATA.
- DATA:
  - Pass W through combinationally: m_w*=s_w*[g], s_wready[g]=m_wready; other s_wready=0.
  - Each W handshake increments beat_cnt.
  - Handshake with s_wlast[g]=1: if beat_cnt≠len_q, set err_len[g]; go to RESP. m_wlast is forwarded unmodified.
  - Handshake where beat_cnt==len_q but wlast=0: set err_len[g]; stay in DATA until wlast.
  - beat_cnt is 9-bit and saturates at 511.
- RESP:
  - s_bvalid[g]=m_bvalid; s_bresp=m_bresp; m_bready=s_bready[g].
  - On m_bvalid&&m_bready: last_grant=g; go to IDLE.
- Ordering and protocol:
  - Only one outstanding burst at a time; W is never interleaved.
  - A new grant is issued no earlier than the cycle after the B handshake.
- err_clr clears all err_len bits. If err_clr and a set event coincide, the set wins.
- Requesters must hold AW fields stable while s_awvalid is high (AXI rule). The block does not re-sample them after the IDLE decision.
- s_awvalid deasserting while in ADDR is a requester protocol violation; behaviour is undefined and not checked.
- Reset asserted mid-burst: immediate return to IDLE with all handshake outputs low. Recovery of the downstream slave is the system's responsibility.

Test Plan:
- Single requester 0, awaddr=0x1000, awlen=3, 4 beats, m_awready/m_wready tied 1, bresp=0 → m_awid=0; 4 W beats with wlast on the 4th; s_bvalid[0] pulses; busy falls the cycle after the B handshake; err_len=0.
- Both requesters assert AW continuously, awlen=0 each → grants alternate 0,1,0,1; m_awid sequence matches; no W overlap.
- Requester 1 only after reset, then both → 1 granted first, then 0 (last_grant=1); no starvation over 8 bursts.
- Back-pressure: m_awready low 5 cycles, m_wready toggling every cycle, m_bvalid delayed 10 cycles → data unchanged across stalls; s_awready[g] mirrors m_awready exactly.
- Length error: awlen=3, wlast asserted on beat 2 → err_len[g]=1 after that handshake, state goes to RESP; err_clr pulse clears it. Second case: wlast absent on beat 4 → err_len set, block waits for wlast.
- Reset asserted during DATA beat 2 → all valid/ready outputs 0 in the same cycle; after release, requester 0 wins the next arbitration.
